counter_rr_scheduler: RTL and testbench

- Shares one CNT_W-bit up-counter (clear + enable style) between NUM_REQ requesters.
- Each requester asks for one timed run of length len. The scheduler grants one requester at a time, clears the counter, and counts to that requester's target.
- Pulses done to the owner when the target is reached, then releases the counter.
- Sits between requesting control blocks and the shared counter resource. It is the sequencer that drives the counter's clear and enable.

---
 rtl/cnt_sched_pkg.sv | 65 ++++++
 rtl/shared_counter_core.sv | 38 +++
 rtl/counter_rr_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_counter_rr_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// -----------------------------------------------------------------------------
// cnt_sched_pkg
//   Shared definitions for the counter round-robin scheduler:
//     - state_e    : scheduler FSM states (IDLE / CLEAR / COUNT / DONE)
//     - ID_W       : owner-index width for the default requester count
//     - rr_pick    : round-robin winner selection, returns a one-hot vector
//     - fp_pick    : fixed-priority winner selection (lowest index wins)
//   The pick functions work on MAX_REQ-wide vectors so that one definition
//   serves every legal NUM_REQ (2..8); callers zero-pad unused requesters.
// -----------------------------------------------------------------------------
package cnt_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);
  localparam int MAX_REQ     = 8;
  localparam int PTR_W       = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // First set bit searching upward from ptr+1, wrapping modulo n.
  // The last owner (ptr) is visited last, which gives the rotation.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] win;
    logic               found;
    logic [PTR_W-1:0]   idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % n);
      if (i <= n && !found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

  // Lowest index wins.
  function automatic logic [MAX_REQ-1:0] fp_pick(
    input logic [MAX_REQ-1:0] req
  );
    logic [MAX_REQ-1:0] win;
    logic               found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/shared_counter_core.sv
// -----------------------------------------------------------------------------
// shared_counter_core
//   CNT_W-bit up-counter with synchronous clear and enable.
//   clear has priority over enable.
// Ports:
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset (counter -> 0)
//   clear       : load zero on the next edge
//   enable      : increment on the next edge
//   counter_out : live counter value
// -----------------------------------------------------------------------------
module shared_counter_core #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] counter_out
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign counter_out = cnt_q;

endmodule

// File: rtl/counter_rr_scheduler.sv
// -----------------------------------------------------------------------------
// counter_rr_scheduler
//   Shares one CNT_W-bit counter between NUM_REQ requesters. A granted owner
//   gets the counter cleared, counted up to its len slice, and a one-cycle
//   done pulse; then the counter is released. Owners that drop req while
//   counting abort the run without a done pulse.
//
// Build option:
//   CNT_SCHED_FIXED_PRIORITY_EN : defined   -> fixed priority, lowest index wins
//                                 undefined -> round-robin from last owner + 1
//
// Ports:
//   clock       : rising-edge clock
//   reset_n     : asynchronous active-low reset
//   req         : per-requester run request (level)
//   len         : per-requester target, slice i = len[i*CNT_W +: CNT_W],
//                 sampled only when that requester is granted
//   grant       : registered one-hot owner indication
//   done        : registered one-cycle completion pulse to the owner
//   busy        : high whenever the FSM is not IDLE
//   active_id   : index of the current or most recent owner
//   counter_out : live value of the shared counter
// -----------------------------------------------------------------------------
module counter_rr_scheduler
  import cnt_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int ACT_W   = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [ACT_W-1:0]         active_id,
  output logic [CNT_W-1:0]         counter_out
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [ACT_W-1:0]   active_id_q, active_id_d;
  logic [CNT_W-1:0]   target_q, target_d;

  logic               cnt_clear;
  logic               cnt_enable;
  logic [CNT_W-1:0]   cnt_val;

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] win_ext;
  logic [NUM_REQ-1:0] winner;
  logic [ACT_W-1:0]   winner_id;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign req_ext = MAX_REQ'(req);

`ifdef CNT_SCHED_FIXED_PRIORITY_EN
  assign win_ext = fp_pick(req_ext);
`else
  // Index of the last owner (completed or aborted); reset value NUM_REQ-1
  // makes requester 0 the first candidate.
  logic [ACT_W-1:0] ptr_q, ptr_d;

  assign win_ext = rr_pick(req_ext, PTR_W'(ptr_q), NUM_REQ);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= ACT_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign winner = win_ext[NUM_REQ-1:0];

  // Padded requester lanes are always zero; the pick never sets them.
  if (NUM_REQ < MAX_REQ) begin : g_pad
    logic unused_win_hi;
    assign unused_win_hi = |win_ext[MAX_REQ-1:NUM_REQ];
  end

  always_comb begin
    winner_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) winner_id = ACT_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state/output logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      active_id_q <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      active_id_q <= active_id_d;
      target_q    <= target_d;
    end
  end

  // NOTE: every variable gets a default before the case statement, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    active_id_d = active_id_q;
    target_d    = target_q;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;
`ifndef CNT_SCHED_FIXED_PRIORITY_EN
    ptr_d       = ptr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d     = winner;
          active_id_d = winner_id;
          target_d    = len[winner_id*CNT_W +: CNT_W];
          state_d     = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        cnt_clear = 1'b1;
        state_d   = ST_COUNT;
      end

      ST_COUNT: begin
        // Abort outranks completion; compare precedes increment, so the
        // counter stops at the target and can never wrap.
        if (!req[active_id_q]) begin
          grant_d = '0;
          state_d = ST_IDLE;
`ifndef CNT_SCHED_FIXED_PRIORITY_EN
          ptr_d   = active_id_q;
`endif
        end else if (cnt_val == target_q) begin
          grant_d              = '0;
          done_d[active_id_q]  = 1'b1;
          state_d              = ST_DONE;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
`ifndef CNT_SCHED_FIXED_PRIORITY_EN
        ptr_d   = active_id_q;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared counter
  // ---------------------------------------------------------------------------
  shared_counter_core #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (cnt_clear),
    .enable      (cnt_enable),
    .counter_out (cnt_val)
  );

  assign grant       = grant_q;
  assign done        = done_q;
  assign busy        = (state_q != ST_IDLE);
  assign active_id   = active_id_q;
  assign counter_out = cnt_val;

endmodule

// File: tb/tb_counter_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_counter_rr_scheduler
//   Self-checking bench for counter_rr_scheduler (default parameters).
//   Each run is predicted at transaction level: the winner is chosen from the
//   pending request set and the last owner, then the expected grant / counter
//   / done waveform for a target L is replayed cycle by cycle.
// -----------------------------------------------------------------------------
module tb_counter_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int AW = $clog2(N);

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [AW-1:0]  active_id;
  logic [W-1:0]   counter_out;

  int checks   = 0;
  int failures = 0;
  int last_owner;

  counter_rr_scheduler #(
    .NUM_REQ (N),
    .CNT_W   (W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .len         (len),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .active_id   (active_id),
    .counter_out (counter_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference arbitration: next pending requester after the last owner.
  function automatic int model_pick(input logic [N-1:0] r, input int last);
`ifdef CNT_SCHED_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  // Called in an IDLE cycle with req != 0. drop_at >= 0 drops the owner's
  // req once counter_out shows that value. noise perturbs len and the other
  // requesters after the grant, which must not affect the run.
  task automatic serve(input int drop_at, input bit noise);
    int w;
    int l;
    w = model_pick(req, last_owner);
    l = int'(len[w*W +: W]);
    tick();
    check("clr_grant", 32'(grant), 32'(1 << w));
    check("clr_busy", 32'(busy), 1);
    check("clr_id", 32'(active_id), 32'(w));
    check("clr_done", 32'(done), 0);
    if (noise) begin
      len = (N*W)'($urandom);
      req = req | N'($urandom);
    end
    for (int k = 0; k <= l; k++) begin
      tick();
      check("cnt_value", 32'(counter_out), 32'(k));
      check("cnt_grant", 32'(grant), 32'(1 << w));
      check("cnt_done", 32'(done), 0);
      if (k == drop_at) begin
        req[w] = 1'b0;
        tick();
        check("abort_grant", 32'(grant), 0);
        check("abort_done", 32'(done), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_hold", 32'(counter_out), 32'(k));
        last_owner = w;
        return;
      end
    end
    tick();
    check("done_pulse", 32'(done), 32'(1 << w));
    check("done_grant", 32'(grant), 0);
    check("done_count", 32'(counter_out), 32'(l));
    check("done_busy", 32'(busy), 1);
    tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_count", 32'(counter_out), 32'(l));
    check("idle_id", 32'(active_id), 32'(w));
    req[w]     = 1'b0;
    last_owner = w;
  endtask

  task automatic set_len(input int idx, input int val);
    len[idx*W +: W] = W'(val);
  endtask

  initial begin
    // Reset
    reset_n    = 1'b0;
    req        = '0;
    len        = '0;
    last_owner = N - 1;
    tick();
    tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(counter_out), 0);
    check("rst_id", 32'(active_id), 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 0);

    // Single request, len=5
    req = 4'b0001;
    set_len(0, 5);
    serve(-1, 1'b0);

    // Round robin with all requesters pending, len=1
    len = {N{W'(1)}};
    for (int i = 0; i < 5; i++) begin
      req = 4'b1111;
      serve(-1, 1'b0);
    end
    req = '0;
    tick();

    // Zero length
    req = 4'b0010;
    set_len(1, 0);
    serve(-1, 1'b0);

    // Abort at counter_out=3, then requester 0 runs from a cleared counter
    req = 4'b0100;
    set_len(2, 9);
    serve(3, 1'b0);
    req = 4'b0001;
    set_len(0, 2);
    serve(-1, 1'b0);

    // Full range: counter stops at all-ones
    req = 4'b1000;
    set_len(3, 15);
    serve(-1, 1'b0);

    // Reset in the middle of a run at counter_out=6
    req = 4'b0100;
    set_len(2, 10);
    tick();
    for (int k = 0; k <= 6; k++) tick();
    check("pre_rst_count", 32'(counter_out), 6);
    reset_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_count", 32'(counter_out), 0);
    req = '0;
    tick();
    reset_n    = 1'b1;
    last_owner = N - 1;
    tick();
    check("rst_release_busy", 32'(busy), 0);
    req = 4'b1001;
    set_len(0, 1);
    set_len(3, 2);
    serve(-1, 1'b0);
    serve(-1, 1'b0);

    // Randomised runs with aborts, late len changes and late requests
    for (int i = 0; i < 40; i++) begin
      int drop;
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      len  = (N*W)'($urandom);
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      serve(drop, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
